// File: rtl/decod_pkg.sv
// Shared definitions for the registered N->2^N decoder: FSM state encoding,
// the address-width limit and the dwell-counter width helper.
package decod_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DIRECT = 2'b01,
    SCAN   = 2'b10
  } state_e;

  localparam int MAX_N = 6;

  // Dwell counter width: clog2(DWELL), never below one bit.
  function automatic int dwell_w(input int dwell);
    return (dwell <= 2) ? 1 : $clog2(dwell);
  endfunction

endpackage

// File: rtl/decod_onehot.sv
// Purely combinational N->2^N one-hot decoder, shared by the DIRECT and SCAN
// paths of decodificador_n_scan.
module decod_onehot #(
  parameter int N = 2
) (
  input  logic [N-1:0]      idx_i,
  output logic [(1<<N)-1:0] onehot_o
);

  assign onehot_o = {{((1 << N) - 1){1'b0}}, 1'b1} << idx_i;

endmodule

// File: rtl/decodificador_n_scan.sv
// Registered N->2^N one-hot decoder with DIRECT (valid/ready) and SCAN
// (autonomous stepping, programmable dwell) modes. Optional sum-of-minterms
// output is built only when DECOD_SOP_EN is defined.
module decodificador_n_scan
  import decod_pkg::*;
#(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                addr_valid,
  input  logic [N-1:0]        addr,
  output logic                addr_ready,
  output logic [(1<<N)-1:0]   y,
  output logic                y_valid,
  output logic [N-1:0]        scan_idx,
  output logic                wrap
`ifdef DECOD_SOP_EN
  ,
  input  logic [(1<<N)-1:0]   sop_mask,
  output logic                sop_out
`endif
);

  localparam int W  = 1 << N;
  localparam int DW = dwell_w(DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   scan_idx_q, scan_idx_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [W-1:0]   y_q, y_d;
  logic           y_valid_q, y_valid_d;
  logic           wrap_q, wrap_d;
  logic           accept, scan_entry, dwell_done;
  logic [N-1:0]   dec_idx;
  logic [W-1:0]   dec_line;

  // NOTE: always_comb blocks assign every output a default first, so no path
  // can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = IDLE;
    if (en) state_d = mode ? SCAN : DIRECT;
  end

  assign addr_ready = (state_q == DIRECT) & en & ~mode;
  assign accept     = addr_valid & addr_ready;
  assign scan_entry = (state_d == SCAN) && (state_q != SCAN);
  assign dwell_done = (dwell_q == DWELL_LAST);

  // Scan position is only kept while staying in SCAN; any other path zeroes it.
  always_comb begin
    scan_idx_d = '0;
    dwell_d    = '0;
    wrap_d     = 1'b0;
    if (state_d == SCAN && !scan_entry) begin
      if (dwell_done) begin
        scan_idx_d = scan_idx_q + N'(1);
        wrap_d     = &scan_idx_q;
      end else begin
        scan_idx_d = scan_idx_q;
        dwell_d    = dwell_q + DW'(1);
      end
    end
  end

  assign dec_idx = (state_d == SCAN) ? scan_idx_d : addr;

  decod_onehot #(.N(N)) u_onehot (
    .idx_i    (dec_idx),
    .onehot_o (dec_line)
  );

  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    unique case (state_d)
      SCAN: begin
        y_d       = dec_line;
        y_valid_d = 1'b1;
      end
      DIRECT: begin
        if (state_q != DIRECT) begin
          y_d       = '0;
          y_valid_d = 1'b0;
        end else if (accept) begin
          y_d       = dec_line;
          y_valid_d = 1'b1;
        end
      end
      default: begin
        y_d       = '0;
        y_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      scan_idx_q <= '0;
      dwell_q    <= '0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      dwell_q    <= dwell_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      wrap_q     <= wrap_d;
    end
  end

  assign y        = y_q;
  assign y_valid  = y_valid_q;
  assign scan_idx = scan_idx_q;
  assign wrap     = wrap_q;

`ifdef DECOD_SOP_EN
  // Registered from next-state y so sop_out lines up with y on the same edge.
  logic sop_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sop_q <= 1'b0;
    else        sop_q <= |(y_d & sop_mask);
  end
  assign sop_out = sop_q;
`endif

endmodule

// File: tb/tb_decodificador_n_scan.sv
// Self-checking bench for decodificador_n_scan (N=2, DWELL=3): directed test-plan
// sequences followed by randomized traffic, compared to an arithmetic reference model.
module tb_decodificador_n_scan;

  localparam int N     = 2;
  localparam int DWELL = 3;
  localparam int W     = 1 << N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, mode, addr_valid;
  logic [N-1:0] addr;
  logic         addr_ready;
  logic [W-1:0] y;
  logic         y_valid;
  logic [N-1:0] scan_idx;
  logic         wrap;
  logic [W-1:0] mask;
`ifdef DECOD_SOP_EN
  logic         sop_out;
`endif

  decodificador_n_scan #(.N(N), .DWELL(DWELL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .addr_valid (addr_valid),
    .addr       (addr),
    .addr_ready (addr_ready),
    .y          (y),
    .y_valid    (y_valid),
    .scan_idx   (scan_idx),
    .wrap       (wrap)
`ifdef DECOD_SOP_EN
    ,
    .sop_mask   (mask),
    .sop_out    (sop_out)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 direct, 2 scan; scan line derived from
  // the number of cycles spent in scan since entry.
  int         m_mode = 0;
  int         m_t    = 0;
  logic [W-1:0] m_y  = '0;
  logic       m_yv   = 1'b0;
  logic       m_wrap = 1'b0;
  int         m_idx  = 0;
  logic       m_sop  = 1'b0;

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_y = '0; m_yv = 1'b0; m_wrap = 1'b0; m_idx = 0; m_sop = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".y"},        32'(y),        32'(m_y));
    check({tag, ".y_valid"},  32'(y_valid),  32'(m_yv));
    check({tag, ".scan_idx"}, 32'(scan_idx), 32'(m_idx));
    check({tag, ".wrap"},     32'(wrap),     32'(m_wrap));
`ifdef DECOD_SOP_EN
    check({tag, ".sop_out"},  32'(sop_out),  32'(m_sop));
`endif
  endtask

  // Called at a negedge: drive, check ready, predict, clock, check outputs.
  task automatic cycle(input string tag, input logic e, input logic m,
                       input logic v, input logic [N-1:0] a);
    en = e; mode = m; addr_valid = v; addr = a;
    #1;
    check({tag, ".addr_ready"}, 32'(addr_ready), 32'((m_mode == 1) && e && !m));
    if (!e) begin
      model_reset();
    end else if (m) begin
      m_t    = (m_mode == 2) ? m_t + 1 : 0;
      m_wrap = (m_mode == 2) && (m_t % (DWELL * W) == 0);
      m_idx  = (m_t / DWELL) % W;
      m_y    = W'(1) << m_idx;
      m_yv   = 1'b1;
      m_mode = 2;
    end else begin
      if (m_mode != 1) begin
        m_y  = '0;
        m_yv = 1'b0;
      end else if (v) begin
        m_y  = W'(1) << a;
        m_yv = 1'b1;
      end
      m_t = 0; m_idx = 0; m_wrap = 1'b0; m_mode = 1;
    end
    m_sop = |(m_y & mask);
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; addr_valid = 1'b0; addr = '0; mask = 4'b0101;
    #12;
    check_outputs("rst");
    check("rst.addr_ready", 32'(addr_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle("idle", 1'b0, 1'b0, 1'b0, 2'd0);

    // DIRECT: entry, two back-to-back acceptances, then hold.
    cycle("d_enter", 1'b1, 1'b0, 1'b0, 2'd3);
    cycle("d_acc2",  1'b1, 1'b0, 1'b1, 2'd2);
    check("d_acc2.literal", 32'(y), 32'h4);
    cycle("d_acc0",  1'b1, 1'b0, 1'b1, 2'd0);
    check("d_acc0.literal", 32'(y), 32'h1);
    cycle("d_hold",  1'b1, 1'b0, 1'b0, 2'd3);

    // SCAN: full period plus wrap, literal wrap check at cycle 13.
    for (int i = 0; i < 14; i++) begin
      cycle("scan", 1'b1, 1'b1, 1'b0, 2'd0);
      if (i == 12) check("scan.wrap_at_12", 32'(wrap), 32'd1);
    end

    // Mode switch mid-scan at index 2, then back to SCAN.
    while (m_idx != 2) cycle("scan_to2", 1'b1, 1'b1, 1'b0, 2'd0);
    cycle("sw_direct", 1'b1, 1'b0, 1'b0, 2'd0);
    cycle("sw_ready",  1'b1, 1'b0, 1'b0, 2'd1);
    cycle("sw_scan",   1'b1, 1'b1, 1'b0, 2'd0);
    check("sw_scan.literal", 32'(y), 32'h1);

    // en drop mid-scan, re-enable restarts at index 0.
    for (int i = 0; i < 5; i++) cycle("scan_b", 1'b1, 1'b1, 1'b0, 2'd0);
    cycle("en_drop", 1'b0, 1'b1, 1'b0, 2'd0);
    cycle("re_scan", 1'b1, 1'b1, 1'b0, 2'd0);

    // Asynchronous reset mid-scan, away from any clock edge.
    for (int i = 0; i < 7; i++) cycle("scan_c", 1'b1, 1'b1, 1'b0, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) cycle("post_rst", 1'b1, 1'b1, 1'b0, 2'd0);

    // Randomized traffic with occasional mode changes and en drops.
    begin
      logic e, m;
      m = 1'b0;
      for (int i = 0; i < 600; i++) begin
        e = ($urandom_range(0, 19) != 0);
        if ($urandom_range(0, 15) == 0) m = ~m;
        mask = W'($urandom);
        cycle("rand", e, m, 1'($urandom), N'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decodificador_n_scan.md
# decodificador_n_scan

Parametrised, registered N→2^N one-hot decoder. It is the sequential successor of the 2→4 decoder used in the digital-circuits lab designs. In DIRECT mode it decodes addresses accepted through a valid/ready handshake. In SCAN mode it steps autonomously through all output lines with a programmable dwell, which suits display-digit or row multiplexing. An optional sum-of-minterms output generalises the f2/f3 derived functions to any mask.

## Interface
- N, 2: address width, legal range 1..6; output width is 2^N.
- DWELL, 4: cycles each line stays active in SCAN, minimum 1.
- clk  in  1: single clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- en  in  1: block enable.
- mode  in  1: 0 = DIRECT, 1 = SCAN.
- addr_valid  in  1: an address is offered.
- addr  in  N: address to decode.
- addr_ready  out  1: address accepted this cycle when valid & ready.
- y  out  2^N: registered one-hot output lines.
- y_valid  out  1: y holds a meaningful line.
- scan_idx  out  N: index currently driven in SCAN mode.
- wrap  out  1: one-cycle pulse when the scan returns to index 0.
- sop_mask  in  2^N: minterm select. Present only with DECOD_SOP_EN.
- sop_out  out  1: registered OR of (y & sop_mask). Present only with DECOD_SOP_EN.

## Operation
- States: IDLE, DIRECT, SCAN.
- Reset values: state=IDLE, y=0, y_valid=0, scan_idx=0, wrap=0, sop_out=0, dwell counter=0.
- IDLE: y=0 and y_valid=0.
  - en=1, mode=0 → DIRECT.
  - en=1, mode=1 → SCAN.
- addr_ready is combinational: addr_ready = (state==DIRECT) & en & ~mode.
- DIRECT:
  - On acceptance (addr_valid & addr_ready), the next edge sets y to onehot(addr) and y_valid to 1.
  - y holds until the next acceptance. Back-to-back acceptances are allowed, one per cycle.
- Entering DIRECT clears y and y_valid. They stay cleared until the first acceptance.
- SCAN:
  - addr_ready=0. y=onehot(scan_idx) and y_valid=1.
  - The dwell counter counts 0..DWELL-1.
  - At DWELL-1, the counter returns to 0 and scan_idx increments modulo 2^N.
- Entering SCAN from any state loads scan_idx=0, dwell=0, y=onehot(0) and y_valid=1 on the same edge.
- wrap=1 for exactly the cycle in which y changes from line 2^N-1 to line 0. Entering SCAN does not raise wrap.
- Mode change while en=1 switches directly between DIRECT and SCAN on the next edge, with the entry rules above.
- en=0 in any state → IDLE on the next edge. All outputs except sop_out return to reset values; scan position is lost.
- Asynchronous reset mid-operation forces reset values immediately, regardless of clk.
- Exactly one bit of y is set whenever y_valid=1; y=0 whenever y_valid=0.

## Timing
- DIRECT latency: 1 cycle from accepting edge to y.
- SCAN: first line appears 1 cycle after en & mode are sampled high. Each index is visible exactly DWELL cycles, so the full period is DWELL·2^N cycles.
- With DWELL=1, y advances every cycle and wrap fires every 2^N cycles.
- sop_out is registered from the next-state value of y, so it is cycle-aligned with y (same edge). It is 0 whenever y=0.

## Configuration
- Macro: DECOD_SOP_EN.
- Defined: sop_mask and sop_out exist.
  - Mask {line0, line2} reproduces f2 = ~B for N=2.
  - Mask {line1, line2} reproduces the f3 core.
- Undefined: sop_mask and sop_out are absent; no extra logic is generated.

## Structure
- Package decod_pkg:
  - State encoding constants: IDLE=2'b00, DIRECT=2'b01, SCAN=2'b10.
  - Maximum N constant (6).
  - Width helper for the dwell counter: clog2(DWELL), minimum 1.
- Sub-module decod_onehot: purely combinational N→2^N decoder, parameter N. It is shared by the DIRECT path (addr) and the SCAN path (scan_idx) through a mux selected by next state.
- Top module holds the FSM, dwell counter, scan_idx and output registers.

## Test plan
- Reset, N=2: hold rst_n=0, then release with en=0 → y=4'b0000, y_valid=0, addr_ready=0, wrap=0.
- DIRECT: en=1, mode=0; addr 2'b10 accepted → one cycle later y=4'b0100, y_valid=1. Then addr 2'b00 back-to-back → y=4'b0001 the following cycle. With addr_valid=0, y holds.
- SCAN, DWELL=3: en=1, mode=1 → y is 0001 ×3, 0010 ×3, 0100 ×3, 1000 ×3, then 0001 with wrap=1 for one cycle. Period is 12 cycles.
- Mode switch mid-scan at scan_idx=2: mode=0 → next cycle y=0, y_valid=0, addr_ready=1. Switching back to SCAN restarts at y=0001.
- en drop or async reset mid-scan: y=0 and y_valid=0 (immediately for reset, next edge for en). Re-enabling SCAN restarts at index 0.
- DECOD_SOP_EN, mask=4'b0101: scan all lines → sop_out=1 on lines 0 and 2, 0 on lines 1 and 3, aligned with y.
